gen_sequencer: RTL and testbench

//  Sequences one Game-of-Life generation over the ROWS-row board held in prev_state.

---
 rtl/gen_sequencer_if.sv | 35 +++
 rtl/gen_sequencer.sv | 110 +++++++++++
 tb/tb_gen_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/gen_sequencer_if.sv
// Control/status bundle between a generation sequencer and its controller.
//   run, step, gen_period        : controller -> sequencer (run control and pacing)
//   rd_addr_up/c/dn              : sequencer -> prev_state read ports (above/centre/below)
//   wr_en, wr_addr               : sequencer -> current_state write port
//   commit, done                 : one-cycle pulse when a generation completes
//   busy, gen_count              : sequencer status
// Modports: master = controller side, slave = sequencer side.
interface gen_sequencer_if #(
    parameter int unsigned REGBITS = 3,
    parameter int unsigned PERW    = 16,
    parameter int unsigned GENW    = 16
);
    logic               run;
    logic               step;
    logic [PERW-1:0]    gen_period;
    logic [REGBITS-1:0] rd_addr_up;
    logic [REGBITS-1:0] rd_addr_c;
    logic [REGBITS-1:0] rd_addr_dn;
    logic               wr_en;
    logic [REGBITS-1:0] wr_addr;
    logic               commit;
    logic               done;
    logic               busy;
    logic [GENW-1:0]    gen_count;

    modport master (
        output run, step, gen_period,
        input  rd_addr_up, rd_addr_c, rd_addr_dn, wr_en, wr_addr, commit, done, busy, gen_count
    );

    modport slave (
        input  run, step, gen_period,
        output rd_addr_up, rd_addr_c, rd_addr_dn, wr_en, wr_addr, commit, done, busy, gen_count
    );
endinterface

// File: rtl/gen_sequencer.sv
// Sequences one Game-of-Life generation over a ROWS-row board: scans rows one per cycle,
// drives the three toroidally-wrapped read addresses and the write strobe, then issues a
// one-cycle commit. Supports single-step and paced free-run.
// Ports:
//   ph1   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : gen_sequencer_if slave modport (run/step/gen_period in; addresses, strobes,
//           busy and gen_count out)
// All outputs are a pure decode of registered state, so there is no input-to-output path.
module gen_sequencer #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned REGBITS = 3,
    parameter int unsigned PERW    = 16,
    parameter int unsigned GENW    = 16
) (
    input logic            ph1,
    input logic            reset,
    gen_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StCompute, StCommit} state_e;

    localparam logic [REGBITS-1:0] LastRow = REGBITS'(ROWS - 1);

    state_e             state_q;
    logic [REGBITS-1:0] row_q;
    logic [PERW-1:0]    wcnt_q;
    logic [GENW-1:0]    gen_count_q;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            wcnt_q      <= '0;
            gen_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.step) begin
                        state_q <= StCompute;
                        row_q   <= '0;
                    end else if (bus.run) begin
                        if (bus.gen_period != '0) begin
                            state_q <= StWait;
                            wcnt_q  <= bus.gen_period - PERW'(1);
                        end else begin
                            state_q <= StCompute;
                            row_q   <= '0;
                        end
                    end
                end
                StWait: begin
                    if (!bus.run) begin
                        state_q <= StIdle;
                    end else if (wcnt_q == '0) begin
                        state_q <= StCompute;
                        row_q   <= '0;
                    end else begin
                        wcnt_q <= wcnt_q - PERW'(1);
                    end
                end
                StCompute: begin
                    // A started generation always runs to completion.
                    if (row_q == LastRow) begin
                        state_q <= StCommit;
                        row_q   <= '0;
                    end else begin
                        row_q <= row_q + REGBITS'(1);
                    end
                end
                StCommit: begin
                    gen_count_q <= gen_count_q + GENW'(1);
                    // Free-run continues with the current pacing; step is ignored here.
                    if (bus.run) begin
                        if (bus.gen_period != '0) begin
                            state_q <= StWait;
                            wcnt_q  <= bus.gen_period - PERW'(1);
                        end else begin
                            state_q <= StCompute;
                            row_q   <= '0;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.rd_addr_up = '0;
        bus.rd_addr_c  = '0;
        bus.rd_addr_dn = '0;
        bus.wr_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.busy       = (state_q != StIdle);
        bus.commit     = (state_q == StCommit);
        bus.done       = (state_q == StCommit);
        bus.gen_count  = gen_count_q;
        if (state_q == StCompute) begin
            bus.wr_en      = 1'b1;
            bus.rd_addr_c  = row_q;
            bus.wr_addr    = row_q;
            bus.rd_addr_up = (row_q == '0) ? LastRow : row_q - REGBITS'(1);
            bus.rd_addr_dn = (row_q == LastRow) ? '0 : row_q + REGBITS'(1);
        end
    end

endmodule

// File: tb/tb_gen_sequencer.sv
// Bench for gen_sequencer: two instances (8 rows / 16-bit count, 5 rows / 2-bit count)
// share stimulus and are compared every cycle against a position-in-generation model.
module tb_gen_sequencer;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [15:0] gen_period;

    int checks   = 0;
    int failures = 0;

    // Model: pos 0 = no generation, 1..rows = computing row pos-1, rows+1 = commit.
    // wleft = WAIT cycles still to spend (0 = not waiting).
    int          rows_c[2] = '{8, 5};
    int unsigned gmod[2]   = '{65536, 4};
    int          m_pos[2];
    int          m_wleft[2];
    int unsigned m_gen[2];

    gen_sequencer_if #(.REGBITS(3), .PERW(16), .GENW(16)) bus_a ();
    gen_sequencer_if #(.REGBITS(3), .PERW(16), .GENW(2))  bus_b ();

    assign bus_a.run        = run;
    assign bus_a.step       = step;
    assign bus_a.gen_period = gen_period;
    assign bus_b.run        = run;
    assign bus_b.step       = step;
    assign bus_b.gen_period = gen_period;

    gen_sequencer #(.ROWS(8), .REGBITS(3), .PERW(16), .GENW(16)) dut_a (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus_a)
    );

    gen_sequencer #(.ROWS(5), .REGBITS(3), .PERW(16), .GENW(2)) dut_b (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k]   = 0;
            m_wleft[k] = 0;
            m_gen[k]   = 0;
        end
    endtask

    task automatic launch(input int k);
        if (run) begin
            if (gen_period == 0) m_pos[k] = 1;
            else m_wleft[k] = int'(gen_period);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_pos[k] >= 1 && m_pos[k] <= rows_c[k]) begin
                m_pos[k]++;
            end else if (m_pos[k] == rows_c[k] + 1) begin
                m_gen[k] = (m_gen[k] + 1) % gmod[k];
                m_pos[k] = 0;
                launch(k);
            end else if (m_wleft[k] > 0) begin
                if (!run) m_wleft[k] = 0;
                else if (m_wleft[k] == 1) begin
                    m_wleft[k] = 0;
                    m_pos[k]   = 1;
                end else m_wleft[k]--;
            end else if (step) begin
                m_pos[k] = 1;
            end else begin
                launch(k);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int n   = rows_c[k];
            bit cmp = (m_pos[k] >= 1 && m_pos[k] <= n);
            int row = m_pos[k] - 1;
            chk("busy", k, (k == 0) ? 32'(bus_a.busy) : 32'(bus_b.busy),
                32'((m_pos[k] != 0) || (m_wleft[k] != 0)));
            chk("wr_en", k, (k == 0) ? 32'(bus_a.wr_en) : 32'(bus_b.wr_en), 32'(cmp));
            chk("wr_addr", k, (k == 0) ? 32'(bus_a.wr_addr) : 32'(bus_b.wr_addr),
                cmp ? row : 0);
            chk("rd_c", k, (k == 0) ? 32'(bus_a.rd_addr_c) : 32'(bus_b.rd_addr_c),
                cmp ? row : 0);
            chk("rd_up", k, (k == 0) ? 32'(bus_a.rd_addr_up) : 32'(bus_b.rd_addr_up),
                cmp ? (row + n - 1) % n : 0);
            chk("rd_dn", k, (k == 0) ? 32'(bus_a.rd_addr_dn) : 32'(bus_b.rd_addr_dn),
                cmp ? (row + 1) % n : 0);
            chk("commit", k, (k == 0) ? 32'(bus_a.commit) : 32'(bus_b.commit),
                32'(m_pos[k] == n + 1));
            chk("done", k, (k == 0) ? 32'(bus_a.done) : 32'(bus_b.done),
                32'(m_pos[k] == n + 1));
            chk("gen_count", k, (k == 0) ? 32'(bus_a.gen_count) : 32'(bus_b.gen_count),
                m_gen[k]);
        end
    endtask

    // Apply inputs after the falling edge, advance the model at the rising edge, and
    // compare on the next falling edge.
    task automatic cycle(input logic r, input logic s, input logic [15:0] p);
        run        = r;
        step       = s;
        gen_period = p;
        @(posedge ph1);
        model_step();
        @(negedge ph1);
        check_all();
    endtask

    initial begin
        logic        r;
        int unsigned seen;
        reset      = 1'b1;
        run        = 1'b0;
        step       = 1'b0;
        gen_period = '0;
        model_reset();
        @(negedge ph1);
        @(negedge ph1);
        check_all();
        reset = 1'b0;

        // Single step, then idle until well after the commit.
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'd0);
        chk("gen_after_step", 0, 32'(bus_a.gen_count), 32'd1);

        // Paced free-run: 12-cycle generations on the 8-row instance.
        for (int i = 0; i < 48; i++) cycle(1'b1, 1'b0, 16'd3);
        // Back-to-back free-run.
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 16'd0);

        // Drop run mid-generation on the 8-row instance, with stray step pulses.
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (m_pos[0] == 5) seen = 1;
            else cycle(1'b1, 1'b0, 16'd0);
        end
        chk("reached_row4", 0, seen, 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'(i % 2), 16'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'd0);

        // Randomized run/step/pacing traffic.
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) r = ~r;
            cycle(r, 1'($urandom_range(0, 7) == 0), 16'($urandom_range(0, 4)));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 16'd0);

        // Asynchronous reset while computing row 5 (commit cycle of the 5-row instance).
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'd0);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge ph1);
        check_all();
        reset = 1'b0;
        cycle(1'b0, 1'b1, 16'd0);
        chk("restart_row0", 0, 32'(bus_a.wr_addr), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'd0);

        // Four single steps to walk the 2-bit counter through its wrap.
        for (int g = 0; g < 4; g++) begin
            cycle(1'b0, 1'b1, 16'd0);
            for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'd0);
        end
        chk("gen_wrap", 1, 32'(bus_b.gen_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
